// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: slot payload, registered port bundle and a
// helper that turns a held slot into an issued writeback.
package wb_arbiter_pkg;

  localparam int unsigned AL_SIZE     = 32;
  localparam int unsigned AL_IDX_BITS = $clog2(AL_SIZE);
  localparam int unsigned XLEN        = 32;
  localparam int unsigned PREG_BITS   = 6;

  // Payload held in a requester slot while it waits for a writeback port.
  typedef struct packed {
    logic [AL_IDX_BITS-1:0] al_idx;
    logic [XLEN-1:0]        data;
    logic [PREG_BITS-1:0]   rd;
    logic                   uses_rd;
  } wb_req_t;

  // One registered writeback port toward the register file / active list.
  typedef struct packed {
    logic                   valid;
    logic [AL_IDX_BITS-1:0] al_idx;
    logic [XLEN-1:0]        data;
    logic [PREG_BITS-1:0]   rd;
    logic                   uses_rd;
  } wb_out_t;

  function automatic wb_out_t wb_issue(input wb_req_t r);
    wb_out_t o;
    o.valid   = 1'b1;
    o.al_idx  = r.al_idx;
    o.data    = r.data;
    o.rd      = r.rd;
    o.uses_rd = r.uses_rd;
    return o;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational rotating-priority picker: grants up to NUM_WB requesters,
// scanning from ptr upward; grant k is the k-th request found.
module wb_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_WB  = 2,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [PTR_W-1:0]               ptr,
  output logic [NUM_WB-1:0][NUM_REQ-1:0] gnt,
  output logic [NUM_WB-1:0]              gnt_valid,
  output logic [PTR_W-1:0]               next_ptr
);

  logic [2*NUM_REQ-1:0]           req_dbl;
  logic [NUM_REQ-1:0]             req_rot;
  logic [NUM_WB-1:0][NUM_REQ-1:0] gnt_rot;
  logic [2*NUM_REQ-1:0]           gnt_dbl;
  int unsigned                    taken;
  int unsigned                    last_ofs;
  int unsigned                    nxt;

  // Rotate requests so bit 0 is the requester at ptr; the scan then runs in
  // fixed order and grants are rotated back afterwards.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  // Scan rotated requests, hand out ports in order, derive the next pointer.
  always_comb begin
    gnt_rot  = '0;
    taken    = 0;
    last_ofs = 0;
    nxt      = 0;
    for (int unsigned o = 0; o < NUM_REQ; o++) begin
      if (req_rot[o] && (taken < NUM_WB)) begin
        for (int unsigned k = 0; k < NUM_WB; k++) begin
          if (taken == k) gnt_rot[k][o] = 1'b1;
        end
        taken    = taken + 1;
        last_ofs = o;
      end
    end
    nxt = 32'(ptr) + last_ofs + 1;
    if (nxt >= NUM_REQ) nxt = nxt - NUM_REQ;
    next_ptr = (taken != 0) ? PTR_W'(nxt) : ptr;
  end

  // Rotate each grant back into requester numbering.
  always_comb begin
    gnt       = '0;
    gnt_valid = '0;
    gnt_dbl   = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      gnt_dbl      = {gnt_rot[k], gnt_rot[k]} << ptr;
      gnt[k]       = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
      gnt_valid[k] = |gnt_rot[k];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per execution unit, rotating-priority
// grant of up to NUM_WB slots per cycle onto registered writeback ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned AL_IDX_W = AL_IDX_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][AL_IDX_W-1:0]   req_al_idx,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       req_data,
  input  logic [NUM_REQ-1:0][PREG_BITS-1:0]  req_rd,
  input  logic [NUM_REQ-1:0]                 req_uses_rd,
  output wb_out_t [NUM_WB-1:0]               wb
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             full;
  wb_req_t [NUM_REQ-1:0]          slot;
  logic [PTR_W-1:0]               ptr;
  logic [PTR_W-1:0]               next_ptr;
  logic [NUM_WB-1:0][NUM_REQ-1:0] gnt;
  logic [NUM_WB-1:0]              gnt_valid;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             accept;
  wb_req_t [NUM_WB-1:0]           pick;

  wb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .NUM_WB  (NUM_WB),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (full),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .next_ptr  (next_ptr)
  );

  // Union of all port grants, per requester.
  always_comb begin
    grant = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (gnt_valid[k]) grant = grant | gnt[k];
    end
  end

  // A slot being drained this cycle can be refilled at the same edge.
  assign req_ready = flush ? '0 : (~full | grant);
  assign accept    = req_valid & req_ready;

  // One-hot select of the granted slot payload for each port.
  always_comb begin
    pick = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[k][i]) pick[k] = slot[i];
      end
    end
  end

  // Slot occupancy and payload: refill wins over drain, flush empties all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      slot <= '0;
    end else if (flush) begin
      full <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          full[i]         <= 1'b1;
          slot[i].al_idx  <= req_al_idx[i];
          slot[i].data    <= req_data[i];
          slot[i].rd      <= req_rd[i];
          slot[i].uses_rd <= req_uses_rd[i];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Registered writeback ports and round-robin pointer; flush keeps ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb  <= '0;
      ptr <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < NUM_WB; k++) wb[k].valid <= 1'b0;
    end else begin
      ptr <= next_ptr;
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (gnt_valid[k]) wb[k] <= wb_issue(pick[k]);
        else              wb[k].valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NW = 2;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             flush;
  logic [NR-1:0]                    req_valid;
  logic [NR-1:0]                    req_ready;
  logic [NR-1:0][AL_IDX_BITS-1:0]   req_al_idx;
  logic [NR-1:0][XLEN-1:0]          req_data;
  logic [NR-1:0][PREG_BITS-1:0]     req_rd;
  logic [NR-1:0]                    req_uses_rd;
  wb_out_t [NW-1:0]                 wb;

  int tests  = 0;
  int errors = 0;
  int cnt [NR];

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_REQ (NR),
    .NUM_WB  (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_al_idx  (req_al_idx),
    .req_data    (req_data),
    .req_rd      (req_rd),
    .req_uses_rd (req_uses_rd),
    .wb          (wb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int unsigned u, input logic [AL_IDX_BITS-1:0] idx,
                       input logic [31:0] d, input logic [5:0] r, input logic ur);
    req_valid[u]   = 1'b1;
    req_al_idx[u]  = idx;
    req_data[u]    = d;
    req_rd[u]      = r;
    req_uses_rd[u] = ur;
  endtask

  function automatic wb_out_t mk(input logic [AL_IDX_BITS-1:0] idx, input logic [31:0] d,
                                 input logic [5:0] r, input logic ur);
    wb_out_t o;
    o.valid = 1'b1; o.al_idx = idx; o.data = d; o.rd = r; o.uses_rd = ur;
    return o;
  endfunction

  // Payload used by the all-units burst: unit u -> al_idx u+1, rd 20+u.
  function automatic wb_out_t burst(input int unsigned u);
    return mk(AL_IDX_BITS'(u + 1), 32'h1000_0000 + u, 6'(20 + u), 1'(u % 2));
  endfunction

  initial begin
    int unsigned src;
    rst = 1'b0; flush = 1'b0; req_valid = '0;
    req_al_idx = '0; req_data = '0; req_rd = '0; req_uses_rd = '0;

    // Reset asserted mid-cycle
    #2 rst = 1'b1;
    #1;
    check("rst_wb0", wb[0], 64'h0);
    check("rst_wb1", wb[1], 64'h0);
    check("rst_ready", req_ready, 4'b1111);
    check("rst_ptr", dut.ptr, 0);
    check("rst_full", dut.full, 0);
    tick();
    rst = 1'b0;

    // Single result from unit 2
    offer(2, 5, 32'hDEAD_BEEF, 12, 1'b1);
    tick();
    req_valid = '0;
    check("single_lat", wb[0].valid, 0);
    check("single_full", dut.full, 4'b0100);
    tick();
    check("single_wb0", wb[0], mk(5, 32'hDEAD_BEEF, 12, 1'b1));
    check("single_wb1v", wb[1].valid, 0);
    check("single_ptr", dut.ptr, 3);
    tick();
    check("single_pulse", wb[0].valid, 0);

    // All four units at once, ptr back to 0 through reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int unsigned u = 0; u < NR; u++) begin
      offer(u, AL_IDX_BITS'(u + 1), 32'h1000_0000 + u, 6'(20 + u), 1'(u % 2));
    end
    tick();
    req_valid = '0;
    check("all_ready1", req_ready, 4'b0011);
    tick();
    check("all_c1_wb0", wb[0], burst(0));
    check("all_c1_wb1", wb[1], burst(1));
    check("all_c1_ptr", dut.ptr, 2);
    check("all_ready2", req_ready, 4'b1111);
    tick();
    check("all_c2_wb0", wb[0], burst(2));
    check("all_c2_wb1", wb[1], burst(3));
    check("all_c2_ptr", dut.ptr, 0);
    tick();
    check("all_idle0", wb[0].valid, 0);
    check("all_idle1", wb[1].valid, 0);

    // Saturation: all units offer on edges 1..21, outputs counted for 20 cycles
    for (int unsigned u = 0; u < NR; u++) cnt[u] = 0;
    for (int unsigned n = 1; n <= 21; n++) begin
      for (int unsigned u = 0; u < NR; u++) begin
        offer(u, AL_IDX_BITS'(u), 32'hA000_0000 | (n << 4) | u, 6'(u), 1'b1);
      end
      tick();
      check("sat_ready", req_ready, (n % 2 == 1) ? 4'b0011 : 4'b1100);
      if (n >= 2) begin
        src = (n == 2) ? 1 : n - 2;
        for (int unsigned k = 0; k < NW; k++) begin
          check("sat_valid", wb[k].valid, 1);
          check("sat_unit", wb[k].al_idx, (n % 2 == 0) ? k : k + 2);
          check("sat_data", wb[k].data,
                32'hA000_0000 | (src << 4) | ((n % 2 == 0) ? k : k + 2));
          if (wb[k].valid) cnt[wb[k].al_idx[1:0]]++;
        end
      end
    end
    req_valid = '0;
    for (int unsigned u = 0; u < NR; u++) check("sat_count", cnt[u], 10);
    tick(); tick(); tick();
    check("sat_drain_ptr", dut.ptr, 0);
    check("sat_drain_full", dut.full, 0);

    // Flush: move ptr to 1, fill units 0,1,3, flush alongside a unit 2 request
    offer(0, 9, 32'h0000_0AA0, 1, 1'b0);
    tick();
    req_valid = '0;
    tick();
    check("pre_wb0", wb[0], mk(9, 32'h0000_0AA0, 1, 1'b0));
    tick();
    check("pre_ptr", dut.ptr, 1);
    offer(0, 10, 32'hF0, 2, 1'b1);
    offer(1, 11, 32'hF1, 3, 1'b1);
    offer(3, 13, 32'hF3, 4, 1'b1);
    tick();
    req_valid = '0;
    check("fl_full", dut.full, 4'b1011);
    offer(2, 12, 32'hF2, 5, 1'b1);
    flush = 1'b1;
    #1;
    check("fl_ready", req_ready, 4'b0000);
    tick();
    flush = 1'b0;
    req_valid = '0;
    #1;
    check("fl_wb0v", wb[0].valid, 0);
    check("fl_wb1v", wb[1].valid, 0);
    check("fl_empty", dut.full, 0);
    check("fl_ptr", dut.ptr, 1);
    check("fl_ready_after", req_ready, 4'b1111);
    for (int unsigned c = 0; c < 2; c++) begin
      tick();
      check("fl_quiet0", wb[0].valid, 0);
      check("fl_quiet1", wb[1].valid, 0);
    end

    // Reset in the middle of saturation traffic
    for (int unsigned u = 0; u < NR; u++) offer(u, AL_IDX_BITS'(u), 32'hC0 + u, 6'(u), 1'b1);
    tick(); tick(); tick();
    check("mid_busy", wb[0].valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wb0", wb[0], 64'h0);
    check("mid_rst_wb1", wb[1], 64'h0);
    check("mid_rst_full", dut.full, 0);
    check("mid_rst_ptr", dut.ptr, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_lat", wb[0].valid, 0);
    tick();
    check("post_rst_v0", wb[0].valid, 1);
    check("post_rst_u0", wb[0].al_idx, 0);
    check("post_rst_u1", wb[1].al_idx, 1);
    req_valid = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
